// File: rtl/ciclo_fetch_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer: state encoding,
// opcode values and instruction field extraction helpers.
package ciclo_fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_DECODE   = 3'd3,
        ST_EXEC     = 3'd4,
        ST_WB       = 3'd5,
        ST_HALT     = 3'd6
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_NOP   = 6'h01;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_LSB = 0;

    function automatic logic [5:0] ir_op(input logic [31:0] ir);
        return ir[OP_LSB +: 6];
    endfunction

    function automatic logic [4:0] ir_rs(input logic [31:0] ir);
        return ir[RS_LSB +: 5];
    endfunction

    function automatic logic [4:0] ir_rt(input logic [31:0] ir);
        return ir[RT_LSB +: 5];
    endfunction

    function automatic logic [4:0] ir_rd(input logic [31:0] ir);
        return ir[RD_LSB +: 5];
    endfunction

    // Only the low four funct bits select an ALU operation.
    function automatic logic [3:0] ir_aluop(input logic [31:0] ir);
        return ir[FUNCT_LSB +: 4];
    endfunction

endpackage

// File: rtl/ciclo_fetch_pc.sv
// Program counter: loads RESET_PC on reset, advances by PC_STEP when told to.
module ciclo_fetch_pc #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Next PC: increment wraps naturally at 2^PC_W.
    always_comb begin
        pc_d = pc_q;
        if (inc_i) begin
            pc_d = pc_q + PC_W'(PC_STEP);
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ciclo_fetch_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer driving the Banco register bank
// and ALU. Owns the IR; the PC lives in ciclo_fetch_pc.
module ciclo_fetch_ctrl
    import ciclo_fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_rvalid,
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_ra2,
    output logic [4:0]      rf_wa,
    output logic            rf_we,
    output logic [3:0]      alu_op,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     ir,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [4:0]  ra1_q, ra1_d;
    logic [4:0]  ra2_q, ra2_d;
    logic [4:0]  wa_q, wa_d;
    logic [3:0]  aluop_q, aluop_d;
    logic        illegal_q, illegal_d;
    logic        resp_take;
    logic [5:0]  op;

    // The response is only meaningful while a fetch is outstanding.
    assign resp_take = (state_q == ST_WAIT_MEM) && imem_rvalid;
    assign op        = ir_op(ir_q);

    ciclo_fetch_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (resp_take),
        .pc_o  (pc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop is honoured only at instruction boundaries.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_FETCH;
            ST_FETCH:    state_d = ST_WAIT_MEM;
            ST_WAIT_MEM: if (imem_rvalid) state_d = ST_DECODE;
            ST_DECODE: begin
                unique case (op)
                    OP_RTYPE: state_d = ST_EXEC;
                    OP_NOP:   state_d = stop ? ST_IDLE : ST_FETCH;
                    default:  state_d = ST_HALT;
                endcase
            end
            ST_EXEC:     state_d = ST_WB;
            ST_WB:       state_d = stop ? ST_IDLE : ST_FETCH;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Strobes and status decoded from the current state.
    always_comb begin
        imem_req = (state_q == ST_FETCH);
        rf_we    = (state_q == ST_WB) && (wa_q != 5'd0);
        busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
        halted   = (state_q == ST_HALT);
    end

    // Next values of IR and the registered datapath controls.
    always_comb begin
        ir_d      = ir_q;
        ra1_d     = ra1_q;
        ra2_d     = ra2_q;
        wa_d      = wa_q;
        aluop_d   = aluop_q;
        illegal_d = illegal_q;
        if (resp_take) begin
            ir_d = imem_rdata;
        end
        if (state_q == ST_DECODE) begin
            ra1_d = ir_rs(ir_q);
            ra2_d = ir_rt(ir_q);
            if (op == OP_RTYPE) begin
                aluop_d = ir_aluop(ir_q);
            end
            if ((op != OP_RTYPE) && (op != OP_NOP) && (op != OP_HALT)) begin
                illegal_d = 1'b1;
            end
        end
        if (state_q == ST_EXEC) begin
            wa_d = ir_rd(ir_q);
        end
    end

    // IR and datapath control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q      <= '0;
            ra1_q     <= '0;
            ra2_q     <= '0;
            wa_q      <= '0;
            aluop_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            ra1_q     <= ra1_d;
            ra2_q     <= ra2_d;
            wa_q      <= wa_d;
            aluop_q   <= aluop_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem_addr = pc;
    assign ir        = ir_q;
    assign rf_ra1    = ra1_q;
    assign rf_ra2    = ra2_q;
    assign rf_wa     = wa_q;
    assign alu_op    = aluop_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ciclo_fetch_ctrl.sv
// Directed bench for ciclo_fetch_ctrl with a latency-programmable memory model.
module tb_ciclo_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [4:0]  rf_ra1, rf_ra2, rf_wa;
    logic        rf_we;
    logic [3:0]  alu_op;
    logic [31:0] pc, ir;
    logic        busy, halted, illegal;

    logic [31:0] mem [0:15];
    int          lat = 1;
    logic        resp_vld = 1'b0;
    logic [31:0] resp_data = '0;
    logic        man_vld = 1'b0;
    logic [31:0] man_data = '0;
    int          we_cnt = 0;
    int          req_cnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          we0, req0;

    assign imem_rvalid = resp_vld | man_vld;
    assign imem_rdata  = man_vld ? man_data : resp_data;

    ciclo_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .rf_ra1      (rf_ra1),
        .rf_ra2      (rf_ra2),
        .rf_wa       (rf_wa),
        .rf_we       (rf_we),
        .alu_op      (alu_op),
        .pc          (pc),
        .ir          (ir),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Memory responder and pulse counters, all on the falling edge.
    initial begin
        logic        pending;
        int          cnt;
        logic [31:0] paddr;
        pending = 1'b0;
        cnt     = 0;
        paddr   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending  = 1'b0;
                resp_vld = 1'b0;
            end else begin
                if (pending) begin
                    if (cnt <= 1) begin
                        resp_vld  = 1'b1;
                        resp_data = mem[paddr[5:2]];
                        pending   = 1'b0;
                    end else begin
                        cnt      = cnt - 1;
                        resp_vld = 1'b0;
                    end
                end else begin
                    resp_vld = 1'b0;
                end
                if (imem_req) begin
                    pending = 1'b1;
                    cnt     = lat;
                    paddr   = imem_addr;
                    req_cnt = req_cnt + 1;
                end
                if (rf_we) we_cnt = we_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_halt();
        for (int k = 0; k < 30; k++) begin
            if (!halted) step();
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0400_0000;

        // Run A: two R-type instructions (rd=4, then rd=0), then HALT.
        mem[0] = 32'h0022_2020;
        mem[1] = 32'h0022_0020;
        mem[2] = 32'hFC00_0000;
        lat = 1;
        do_reset();
        chk("rst_pc", pc, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_ctl", {15'd0, rf_we, rf_ra1, rf_ra2, rf_wa, alu_op}, 32'd0);
        we0 = we_cnt;
        pulse_start();
        chk("A_fetch_req", {31'd0, imem_req}, 32'd1);
        chk("A_fetch_addr", imem_addr, 32'd0);
        step();
        chk("A_wait_busy", {31'd0, busy}, 32'd1);
        chk("A_wait_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("A_dec_ir", ir, 32'h0022_2020);
        chk("A_dec_pc", pc, 32'd4);
        step();
        chk("A_exec_ra", {22'd0, rf_ra1, rf_ra2}, {22'd0, 5'd1, 5'd2});
        chk("A_exec_aluop", {28'd0, alu_op}, 32'd0);
        step();
        chk("A_wb_wa", {27'd0, rf_wa}, 32'd4);
        chk("A_wb_we", {31'd0, rf_we}, 32'd1);
        step();
        chk("A_next_req", {31'd0, imem_req}, 32'd1);
        chk("A_next_addr", imem_addr, 32'd4);
        chk("A_we_off", {31'd0, rf_we}, 32'd0);
        step();
        step();
        chk("A2_ir", ir, 32'h0022_0020);
        step();
        step();
        chk("A2_wb_wa", {27'd0, rf_wa}, 32'd0);
        chk("A2_wb_we", {31'd0, rf_we}, 32'd0);
        step();
        chk("A2_refetch", {31'd0, imem_req}, 32'd1);
        chk("A2_refetch_addr", imem_addr, 32'd8);
        wait_halt();
        chk("A_halt_pc", pc, 32'd12);
        chk("A_halt_busy", {31'd0, busy}, 32'd0);
        chk("A_we_pulses", we_cnt - we0, 32'd1);

        // Run B: 5-cycle memory latency, then stop raised during EXEC.
        mem[0] = 32'h0043_1825;
        lat = 5;
        do_reset();
        req0 = req_cnt;
        we0 = we_cnt;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("B_wait_ir", ir, 32'd0);
            chk("B_wait_busy", {31'd0, busy, imem_req}, 32'd2);
        end
        step();
        chk("B_wait_ir_last", ir, 32'd0);
        step();
        chk("B_dec_ir", ir, 32'h0043_1825);
        chk("B_req_once", req_cnt - req0, 32'd1);
        step();
        chk("B_exec", {19'd0, rf_ra1, rf_ra2, alu_op}, {19'd0, 5'd2, 5'd3, 4'd5});
        stop = 1'b1;
        step();
        chk("B_wb_we", {31'd0, rf_we}, 32'd1);
        chk("B_wb_wa", {27'd0, rf_wa}, 32'd3);
        chk("B_wb_aluop", {28'd0, alu_op}, 32'd5);
        step();
        chk("B_idle_busy", {31'd0, busy}, 32'd0);
        chk("B_idle_req", {31'd0, imem_req}, 32'd0);
        stop = 1'b0;
        step();
        chk("B_stay_idle", {30'd0, busy, imem_req}, 32'd0);
        chk("B_we_pulses", we_cnt - we0, 32'd1);

        // Run C: NOP then HALT; a later start must be ignored.
        mem[0] = 32'h0400_0000;
        mem[1] = 32'hFC00_0000;
        lat = 1;
        do_reset();
        we0 = we_cnt;
        req0 = req_cnt;
        pulse_start();
        wait_halt();
        chk("C_pc", pc, 32'd8);
        chk("C_no_we", we_cnt - we0, 32'd0);
        chk("C_illegal", {31'd0, illegal}, 32'd0);
        pulse_start();
        step();
        step();
        chk("C_still_halted", {31'd0, halted}, 32'd1);
        chk("C_no_refetch", req_cnt - req0, 32'd2);
        chk("C_pc_hold", pc, 32'd8);

        // Run D: unknown opcode 6'h12.
        mem[0] = 32'h4800_0000;
        do_reset();
        we0 = we_cnt;
        pulse_start();
        wait_halt();
        chk("D_illegal", {31'd0, illegal}, 32'd1);
        chk("D_pc", pc, 32'd4);
        chk("D_no_we", we_cnt - we0, 32'd0);

        // Run E: reset asserted while waiting on the second fetch.
        mem[0] = 32'h0400_0000;
        mem[1] = 32'h0022_2020;
        lat = 1;
        do_reset();
        chk("E_rst_illegal", {31'd0, illegal}, 32'd0);
        pulse_start();
        step();
        step();
        lat = 5;
        step();
        chk("E_fetch2_addr", imem_addr, 32'd4);
        step();
        chk("E_pre_ir", ir, 32'h0400_0000);
        rst_n = 1'b0;
        #1;
        chk("E_async_pc", pc, 32'd0);
        chk("E_async_ir", ir, 32'd0);
        chk("E_async_busy", {31'd0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        req0 = req_cnt;
        man_data = 32'h0022_2020;
        man_vld = 1'b1;
        step();
        man_vld = 1'b0;
        chk("E_late_ir", ir, 32'd0);
        chk("E_late_pc", pc, 32'd0);
        step();
        chk("E_late_busy", {30'd0, busy, imem_req}, 32'd0);
        chk("E_no_req", req_cnt - req0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/ciclo_fetch_ctrl.md
Name: ciclo_fetch_ctrl

Overview:
Multi-cycle fetch/decode/execute sequencer for the register-bank + ALU datapath (Banco).
- Owns the PC and instruction register (IR).
- Fetches 32-bit instructions from instruction memory over a req/valid handshake, then decodes them.
- Drives the register-bank read/write addresses, ALU operation and write enable one phase at a time.
- Sits between the instruction memory and Banco; the datapath itself carries no control state.

Parameters:
PC_W, 32, PC and memory address width.
RESET_PC, 0, PC value loaded on reset.
PC_STEP, 4, PC increment per fetched instruction (byte addressing).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; leaves IDLE and begins fetching at the current PC
stop  in  1  level; finish the current instruction, then return to IDLE
imem_req  out  1  fetch request, one-cycle pulse
imem_addr  out  PC_W  fetch address, equals pc while a request is outstanding
imem_rdata  in  32  instruction word, sampled when imem_rvalid=1
imem_rvalid  in  1  memory response strobe, 1 or more cycles after imem_req
rf_ra1  out  5  register-bank read address A, from IR rs
rf_ra2  out  5  register-bank read address B, from IR rt
rf_wa  out  5  register-bank write address, from IR rd
rf_we  out  1  register-bank write enable, one-cycle pulse
alu_op  out  4  ALU operation select, from IR funct[3:0]
pc  out  PC_W  current PC
ir  out  32  instruction register
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
illegal  out  1  sticky; set on an unknown opcode

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, all strobes 0, rf_* addresses 0, alu_op=0, illegal=0.
- Instruction fields: op=ir[31:26], rs=ir[25:21], rt=ir[20:16], rd=ir[15:11], funct=ir[5:0].
- Opcodes:
  - 6'h00 = R-type ALU.
  - 6'h01 = NOP.
  - 6'h3F = HALT.
  - Any other opcode = illegal.
- FSM states: IDLE, FETCH, WAIT_MEM, DECODE, EXEC, WB, HALT.
- IDLE: outputs quiescent. start=1 -> FETCH.
- FETCH: imem_req=1 for exactly one cycle, imem_addr=pc. -> WAIT_MEM.
- WAIT_MEM: holds until imem_rvalid=1; then ir<=imem_rdata and pc<=pc+PC_STEP (wraps modulo 2^PC_W). -> DECODE.
  - imem_rvalid in any other state is ignored.
  - No timeout.
- DECODE: rf_ra1=rs and rf_ra2=rt, both registered and held until the next DECODE.
  - R-type -> EXEC.
  - NOP -> FETCH.
  - HALT -> HALT.
  - Illegal -> illegal<=1, then HALT.
- EXEC: alu_op=funct[3:0], held stable through WB. -> WB.
- WB: rf_wa=rd; rf_we=1 for one cycle, except when rd==0 (r0 is read-only, rf_we stays 0). -> FETCH, or IDLE if stop=1.
- stop sampling: stop is checked only in WB and on the NOP exit from DECODE; it never aborts mid-instruction.
- Cycle counts: an R-type instruction with 1-cycle memory latency takes 5 cycles, FETCH through WB.
- HALT: terminal; only rst_n leaves it. start is ignored in HALT.
- start in any non-IDLE state is ignored.
- Reset mid-operation (any state, including WAIT_MEM): immediate return to reset values. A late imem_rvalid after reset is ignored because the FSM is in IDLE.

Decomposition:
- Shared package: opcode constants OP_RTYPE, OP_NOP, OP_HALT; state encoding typedef; field-position constants for op/rs/rt/rd/funct.
- Sub-module ciclo_fetch_pc: PC register with load-on-reset and increment-enable. Everything else stays in the FSM module.

Test Plan:
- Reset, then start; mem returns 0x0022_2020 (op=0, rs=1, rt=2, rd=4, funct=0x20) after 1 cycle -> imem_addr=0; rf_ra1=1, rf_ra2=2; alu_op=0; rf_wa=4 with a single rf_we pulse; pc=4; next imem_req issued with addr=4.
- R-type with rd=0 (0x0022_0020) -> no rf_we pulse; FSM returns to FETCH.
- Memory delays imem_rvalid by 5 cycles -> FSM stays in WAIT_MEM, imem_req pulses exactly once, ir unchanged until the strobe.
- Sequence NOP (0x0400_0000) then HALT (0xFC00_0000) -> no rf_we pulse; halted=1 with pc=8; a later start is ignored.
- Opcode 6'h12 -> illegal=1, halted=1, no rf_we pulse.
- stop raised during EXEC -> instruction completes with its rf_we pulse, then IDLE.
- rst_n dropped during WAIT_MEM -> immediate reset values; imem_rvalid one cycle later has no effect.
